// File: rtl/divider_if.sv
// ============================================================================
// Module      : divider_if
// Description : Request/response bundle between a CPU core and the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divider_if;
    logic        start;
    logic        op_unsigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;

    modport master (
        output start, op_unsigned, dividend, divisor,
        input  busy, done, quo, rem
    );

    modport slave (
        input  start, op_unsigned, dividend, divisor,
        output busy, done, quo, rem
    );
endinterface

`default_nettype wire

// File: rtl/divider.sv
// ============================================================================
// Module      : divider
// Description : 32-bit iterative restoring divider, floor-signed or unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider (
    input  wire logic  clk,
    input  wire logic  rst,
    divider_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_neg;
    logic [31:0] r_divisor;
    logic [31:0] r_work;     // dividend bits shift out, quotient bits shift in
    logic [31:0] r_part;     // partial remainder
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_quo;
    logic [31:0] r_rem;

    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_part_next;
    logic [31:0] w_work_next;
    logic        w_neg_in;
    logic [31:0] w_mag_in;
    logic [31:0] w_quo_fin;
    logic [31:0] w_rem_fin;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    always_comb begin
        w_shift     = {r_part, r_work[31]};
        w_diff      = {1'b0, w_shift} - {2'b00, r_divisor};
        w_borrow    = w_diff[33];
        w_part_next = w_borrow ? w_shift[31:0] : w_diff[31:0];
        w_work_next = {r_work[30:0], ~w_borrow};
    end

    always_comb begin
        w_neg_in = ~bus.op_unsigned & bus.dividend[31];
        w_mag_in = w_neg_in ? (32'd0 - bus.dividend) : bus.dividend;
    end

    // Negative dividends are corrected to floor semantics (0 <= rem < divisor).
    always_comb begin
        w_quo_fin = w_work_next;
        w_rem_fin = w_part_next;
        if (r_neg) begin
            if (w_part_next != 32'd0) begin
                w_quo_fin = ~w_work_next;
                w_rem_fin = r_divisor - w_part_next;
            end else begin
                w_quo_fin = 32'd0 - w_work_next;
                w_rem_fin = 32'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_neg     <= 1'b0;
            r_divisor <= 32'd0;
            r_work    <= 32'd0;
            r_part    <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_RUN;
                        r_cnt     <= 6'd0;
                        r_neg     <= w_neg_in;
                        r_divisor <= bus.divisor;
                        r_work    <= w_mag_in;
                        r_part    <= 32'd0;
                        r_busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt  <= r_cnt + 6'd1;
                    r_work <= w_work_next;
                    r_part <= w_part_next;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_quo   <= w_quo_fin;
                        r_rem   <= w_rem_fin;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.quo  = r_quo;
    assign bus.rem  = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module      : tb_divider
// Description : Scoreboard bench for the divider with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider;

    logic clk;
    logic rst;
    divider_if bus ();

    divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [63:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got quo=0x%08h rem=0x%08h expected no result",
                         bus.quo, bus.rem);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("quo", bus.quo, e[63:32]);
                check("rem", bus.rem, e[31:0]);
            end
        end
    end

    // mode 0: plain; 1: new start with other inputs before edge 10; 2: start during FIN
    task automatic run(input logic opu, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eq, input logic [31:0] er, input int mode);
        int busy_n;
        int done_at;
        sb_q.push_back({eq, er});
        @(negedge clk);
        bus.start       = 1'b1;
        bus.op_unsigned = opu;
        bus.dividend    = x;
        bus.divisor     = y;
        @(posedge clk);
        busy_n  = 0;
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (mode == 1 && k == 9) begin
                bus.start       = 1'b1;
                bus.op_unsigned = 1'b1;
                bus.dividend    = 32'd9;
                bus.divisor     = 32'd3;
            end
            if (mode == 2 && k == 32) bus.start = 1'b1;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1 && done_at < 0) done_at = k;
            if (bus.busy !== 1'b1) begin
                bus.start = 1'b0;
                break;
            end
        end
        check("busy_cycles", busy_n, 33);
        check("done_cycle", done_at, 32);
        if (mode == 2) begin
            @(negedge clk);
            check("start_in_fin_ignored", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.start       = 1'b0;
        bus.op_unsigned = 1'b1;
        bus.dividend    = 32'd0;
        bus.divisor     = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quo", bus.quo, 32'd0);
        check("rst_rem", bus.rem, 32'd0);
        rst = 1'b0;

        run(1'b1, 32'd100,       32'd7,          32'd14,         32'd2,          0);
        run(1'b0, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFC,   32'd1,          0);
        run(1'b0, 32'hFFFFFFF8,  32'd2,          32'hFFFFFFFC,   32'd0,          0);
        run(1'b0, 32'h80000000,  32'd1,          32'h80000000,   32'd0,          0);
        run(1'b1, 32'hFFFFFFFF,  32'h10,         32'h0FFFFFFF,   32'hF,          0);
        run(1'b1, 32'd5,         32'd0,          32'hFFFFFFFF,   32'd5,          0);
        run(1'b0, 32'hFFFFFFFB,  32'd0,          32'h00000000,   32'hFFFFFFFB,   0);
        run(1'b0, 32'h7FFFFFFF,  32'd0,          32'hFFFFFFFF,   32'h7FFFFFFF,   0);
        run(1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          0);
        run(1'b1, 32'h80000000,  32'd1,          32'h80000000,   32'd0,          0);
        run(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   0);
        run(1'b1, 32'd100,       32'd7,          32'd14,         32'd2,          1);
        run(1'b1, 32'd1000,      32'd10,         32'd100,        32'd0,          2);

        // Abort mid-run: no expectation pushed, so any done pulse is flagged.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.op_unsigned = 1'b1;
        bus.dividend    = 32'd100;
        bus.divisor     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quo", bus.quo, 32'd0);
        check("abort_rem", bus.rem, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
        run(1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 op_unsigned  input  1  1 = unsigned dividend, 0 = signed (two's complement) dividend; sampled with start.
REQ-006 dividend  input  32  dividend; sampled with start.
REQ-007 divisor  input  32  divisor, always unsigned magnitude; sampled with start.
REQ-008 busy  output  1  high while a division is in progress; the CPU uses it as its stall.
REQ-009 done  output  1  one-cycle pulse; quo/rem are valid from this cycle on.
REQ-010 quo  output  32  quotient, registered.
REQ-011 rem  output  32  remainder, registered.

Function
REQ-012 The block SHALL implement states IDLE, RUN and FIN.
REQ-013 Transitions SHALL be: IDLE->RUN on start; RUN->FIN after exactly 32 iterations; FIN->IDLE unconditionally.
REQ-014 When start is high in IDLE, the block SHALL capture the inputs and set neg = ~op_unsigned & dividend[31].
REQ-015 At that same edge, the working dividend SHALL be loaded as |dividend| when neg=1, else dividend unmodified.
REQ-016 A 6-bit iteration counter SHALL be loaded with 0 at start and incremented once per RUN cycle.
REQ-017 Each RUN cycle SHALL perform one restoring shift-subtract step on a 33-bit partial remainder (remainder:working-dividend shifted left 1; subtract divisor if no borrow; quotient bit = no-borrow).
REQ-018 busy SHALL be high in RUN and FIN and low in IDLE.
REQ-019 done SHALL be high only in FIN, for exactly one cycle.
REQ-020 Latency: start sampled at edge 0 -> busy high from edge 0 to edge 33 -> done high in the cycle after edge 32 -> back to IDLE after edge 33.
REQ-021 Unsigned results SHALL be q = floor(x/y) and r = x - q*y.
REQ-022 Signed results with neg=1 and r'≠0 SHALL be quo = ~q' (i.e. -q'-1) and rem = divisor - r', where q', r' are the raw unsigned results on |dividend|.
REQ-023 Signed results with neg=1 and r'=0 SHALL be quo = -q' and rem = 0; this yields floor semantics with 0 <= rem < divisor.
REQ-024 quo/rem SHALL be written only on the edge entering FIN, and SHALL hold their values until the next FIN.
REQ-025 start while RUN or FIN SHALL be ignored; new inputs SHALL NOT disturb an operation in progress.
REQ-026 start in the same cycle as FIN SHALL be ignored; the next accepted start is the first one seen in IDLE.
REQ-027 Divide by zero: unsigned, or signed with a non-negative dividend, SHALL give quo = 0xFFFFFFFF and rem = dividend.
REQ-028 Divide by zero: signed with a negative dividend SHALL give quo = 0x00000000 and rem = dividend.
REQ-029 Dividend 0x80000000 in signed mode SHALL use magnitude 0x80000000 (33-bit safe); no overflow flag exists.
REQ-030 Quotient and remainder arithmetic SHALL wrap modulo 2^32.

Reset
REQ-031 While rst is high, the state SHALL be IDLE.
REQ-032 While rst is high, busy=0, done=0, quo=0, rem=0, the counter=0 and neg=0.
REQ-033 rst asserted mid-RUN SHALL abort the operation immediately (asynchronously); no done pulse follows and quo/rem read 0.
REQ-034 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-035 Unsigned 100/7, start at edge 0 -> busy high for 33 cycles, done pulse after edge 32, quo=14, rem=2.
REQ-036 Signed 0xFFFFFFF9 (-7) / 2 -> quo=0xFFFFFFFC (-4), rem=1; signed -8/2 -> quo=0xFFFFFFFC, rem=0.
REQ-037 Signed 0x80000000 / 1 -> quo=0x80000000, rem=0; unsigned 0xFFFFFFFF / 0x10 -> quo=0x0FFFFFFF, rem=0xF.
REQ-038 Unsigned 5/0 -> quo=0xFFFFFFFF, rem=5; signed 0xFFFFFFFB / 0 -> quo=0, rem=0xFFFFFFFB.
REQ-039 start 100/7, then start 9/3 with changed inputs at edge 10 -> result 14/2 only, a single done pulse, busy low after edge 33.
REQ-040 start, then rst pulsed at edge 10 -> busy=0, done never asserts, quo=rem=0; a following 9/3 start gives quo=3, rem=0.
